nios_mult_combine: RTL and testbench

Downstream stage of the Nios II M-stage multiplier cell: accepts the three registered 16x16 unsigned partial products (lo*lo, lo*hi, hi*lo) and combines them into the low 32 bits of the 32x32 product. The combine is a two-stage valid/ready pipeline with a destination-register tag, stall and flush. Its `in_ready` drives the multiplier cell's `M_en`, so partial products are held while the stage stalls. The result goes to the writeback mux.

---
 rtl/nios_mult_combine.sv | 131 +++++++++++++
 tb/tb_nios_mult_combine.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/nios_mult_combine.sv
// Low-word combine stage for the Nios II 32x32 multiplier: pipelines lo*lo, lo*hi and hi*lo into the low product word.
// Optional output register stage enabled by defining NIOS_MULT_COMBINE_OUT_REG_EN.
module nios_mult_combine #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      p1,
  input  logic [31:0]      p2,
  input  logic [31:0]      p3,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  logic             s1_valid;
  logic [15:0]      s1_mid;
  logic [31:0]      s1_p1;
  logic [TAG_W-1:0] s1_tag;

  logic             s2_valid;
  logic [31:0]      s2_res;
  logic [TAG_W-1:0] s2_tag;

  logic s1_load;
  logic s2_load;
  logic s2_drain;
  logic s2_ready;

  // Upper halves of the cross products only affect bits above 31, so they are dropped.
  logic unused_hi;
  assign unused_hi = ^{p2[31:16], p3[31:16]};

  assign s2_ready = !s2_valid || s2_drain;
  assign s2_load  = s1_valid && s2_ready;
  assign in_ready = !s1_valid || s2_ready;
  assign s1_load  = in_valid && in_ready;

`ifdef NIOS_MULT_COMBINE_OUT_REG_EN
  logic             s3_valid;
  logic [31:0]      s3_res;
  logic [TAG_W-1:0] s3_tag;
  logic             s3_load;

  assign s2_drain = !s3_valid || out_ready;
  assign s3_load  = s2_valid && s2_drain;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s3_valid <= 1'b0;
    end else if (flush) begin
      s3_valid <= 1'b0;
    end else if (s3_load) begin
      s3_valid <= 1'b1;
    end else if (out_ready) begin
      s3_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s3_res <= '0;
      s3_tag <= '0;
    end else if (s3_load) begin
      s3_res <= s2_res;
      s3_tag <= s2_tag;
    end
  end

  assign out_valid  = s3_valid;
  assign out_result = s3_res;
  assign out_tag    = s3_tag;
  assign busy       = s1_valid | s2_valid | s3_valid;
`else
  assign s2_drain   = out_ready;
  assign out_valid  = s2_valid;
  assign out_result = s2_res;
  assign out_tag    = s2_tag;
  assign busy       = s1_valid | s2_valid;
`endif

  // NOTE: state registers use non-blocking assignments so every stage samples pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else if (flush) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (s1_load) begin
        s1_valid <= 1'b1;
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end
      if (s2_load) begin
        s2_valid <= 1'b1;
      end else if (s2_drain) begin
        s2_valid <= 1'b0;
      end
    end
  end

  // NOTE: data registers are reset too so the outputs read zero while the pipeline is empty after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_mid <= '0;
      s1_p1  <= '0;
      s1_tag <= '0;
      s2_res <= '0;
      s2_tag <= '0;
    end else begin
      if (s1_load) begin
        s1_mid <= p2[15:0] + p3[15:0];
        s1_p1  <= p1;
        s1_tag <= in_tag;
      end
      if (s2_load) begin
        s2_res <= s1_p1 + {s1_mid, 16'h0000};
        s2_tag <= s1_tag;
      end
    end
  end

endmodule

// File: tb/tb_nios_mult_combine.sv
// Directed bench for nios_mult_combine: basic, wrap-around, streaming, stall, flush and async reset.
// Honours NIOS_MULT_COMBINE_OUT_REG_EN for the expected latency.
module tb_nios_mult_combine;

  localparam int TAG_W = 5;
`ifdef NIOS_MULT_COMBINE_OUT_REG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic             clk = 1'b0;
  logic             reset_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      p1, p2, p3;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_result;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] sa [8];
  logic [31:0] sb [8];
  logic [31:0] exp_res [8];

  nios_mult_combine #(.TAG_W(TAG_W)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .p1(p1), .p2(p2), .p3(p3), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_src(input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] t);
    in_valid = 1'b1;
    p1 = {16'h0000, a[15:0]}  * {16'h0000, b[15:0]};
    p2 = {16'h0000, a[15:0]}  * {16'h0000, b[31:16]};
    p3 = {16'h0000, a[31:16]} * {16'h0000, b[15:0]};
    in_tag = t;
  endtask

  initial begin
    int acc;
    int nout;
    int j;
    logic go;

    for (int i = 0; i < 8; i++) begin
      sa[i] = 32'h1357_9BDF + i * 32'h0F0F_1111;
      sb[i] = 32'h2468_ACE0 ^ (i * 32'h0011_0101);
      exp_res[i] = sa[i] * sb[i];
    end

    // Reset values
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    p1 = '0; p2 = '0; p3 = '0; in_tag = '0;
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_result", out_result, 32'd0);
    check("rst_out_tag", 32'(out_tag), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // Basic product
    out_ready = 1'b1;
    in_valid = 1'b1; p1 = 32'h0000_000F; p2 = 32'h0000_0006; p3 = 32'h0000_0005; in_tag = 5'd7;
    tick();
    in_valid = 1'b0;
    check("basic_early_valid", 32'(out_valid), 32'd0);
    check("basic_busy", 32'(busy), 32'd1);
    repeat (LAT - 2) tick();
    tick();
    check("basic_valid", 32'(out_valid), 32'd1);
    check("basic_result", out_result, 32'h000B_000F);
    check("basic_tag", 32'(out_tag), 32'd7);
    tick();
    check("basic_drained", 32'(out_valid), 32'd0);
    check("basic_idle", 32'(busy), 32'd0);

    // Wrap-around: src1 = src2 = 0xFFFFFFFF
    in_valid = 1'b1; p1 = 32'hFFFE_0001; p2 = 32'hFFFE_0001; p3 = 32'hFFFE_0001; in_tag = 5'd3;
    tick();
    in_valid = 1'b0;
    repeat (LAT - 1) tick();
    check("wrap_valid", 32'(out_valid), 32'd1);
    check("wrap_result", out_result, 32'h0000_0001);
    check("wrap_tag", 32'(out_tag), 32'd3);
    tick();

    // Streaming: 8 back-to-back products
    for (int k = 0; k <= 8 + LAT - 2; k++) begin
      if (k < 8) drive_src(sa[k], sb[k], 5'(k + 8));
      else in_valid = 1'b0;
      #1;
      if (k < 8) check("stream_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      j = k - (LAT - 1);
      check("stream_out_valid", 32'(out_valid), 32'(j >= 0 && j < 8));
      if (j >= 0 && j < 8) begin
        check("stream_result", out_result, exp_res[j]);
        check("stream_tag", 32'(out_tag), 32'(j + 8));
      end
    end
    in_valid = 1'b0;
    tick();
    check("stream_idle", 32'(busy), 32'd0);

    // Stall: out_ready low for 5 cycles while feeding 3 products
    out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 5; c++) begin
      if (acc < 3) drive_src(sa[acc], sb[acc], 5'(16 + acc));
      else in_valid = 1'b0;
      #1;
      check("stall_in_ready", 32'(in_ready), 32'(acc < LAT));
      go = (acc < 3) && (acc < LAT);
      @(posedge clk);
      #1;
      if (go) acc++;
      if (c >= LAT - 1) begin
        check("stall_out_valid", 32'(out_valid), 32'd1);
        check("stall_result_stable", out_result, exp_res[0]);
        check("stall_tag_stable", 32'(out_tag), 32'd16);
      end
    end
    out_ready = 1'b1;
    nout = 0;
    for (int c = 0; c < 8; c++) begin
      if (acc < 3) drive_src(sa[acc], sb[acc], 5'(16 + acc));
      else in_valid = 1'b0;
      #1;
      go = in_valid && in_ready;
      if (out_valid) begin
        if (nout < 3) begin
          check("release_result", out_result, exp_res[nout]);
          check("release_tag", 32'(out_tag), 32'(16 + nout));
        end
        nout++;
      end
      @(posedge clk);
      #1;
      if (go) acc++;
    end
    in_valid = 1'b0;
    check("release_count", 32'(nout), 32'd3);

    // Flush with every stage full and a same-cycle input offered
    out_ready = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      drive_src(sa[i + 3], sb[i + 3], 5'(24 + i));
      tick();
    end
    drive_src(sa[6], sb[6], 5'd30);
    flush = 1'b1;
    #1;
    check("preflush_busy", 32'(busy), 32'd1);
    check("preflush_out_valid", 32'(out_valid), 32'd1);
    check("preflush_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i <= LAT; i++) begin
      tick();
      check("flush_no_ghost", 32'(out_valid), 32'd0);
    end

    // Async reset pulse between edges mid-stream
    drive_src(sa[0], sb[0], 5'd1);
    tick();
    drive_src(sa[1], sb[1], 5'd2);
    tick();
    in_valid = 1'b0;
    #1;
    check("prereset_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check("areset_out_valid", 32'(out_valid), 32'd0);
    check("areset_out_result", out_result, 32'd0);
    check("areset_out_tag", 32'(out_tag), 32'd0);
    check("areset_busy", 32'(busy), 32'd0);
    check("areset_in_ready", 32'(in_ready), 32'd1);
    reset_n = 1'b1;
    in_valid = 1'b1; p1 = 32'h0000_000F; p2 = 32'h0000_0006; p3 = 32'h0000_0005; in_tag = 5'd9;
    tick();
    in_valid = 1'b0;
    repeat (LAT - 1) tick();
    check("post_reset_valid", 32'(out_valid), 32'd1);
    check("post_reset_result", out_result, 32'h000B_000F);
    check("post_reset_tag", 32'(out_tag), 32'd9);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
